// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: key debouncing, mode FSM with reset handshake and sleep timeout,
// and a mode-qualified light-pen write enable for the display RAM.
module led_mode_ctrl #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter logic [31:0] SLEEP_CYCLES    = 32'd500_000_000,
  parameter logic [31:0] RST_TIMEOUT     = 32'd300_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_rst,
  input  logic       key_stop,
  input  logic       key_mode,
  input  logic       pen_raw,
  input  logic       rst_ok,
  output logic [2:0] state,
  output logic       pen_we,
  output logic       rst_fault
);
  // Encoding follows the st_state.v macro values 0..7 in this order.
  typedef enum logic [2:0] {RST, LIGHT, DRAW, ERASE, COLOR, WRITE, STOP, SLEEP} mode_t;
  mode_t cur, nxt, last, last_nxt;
  logic [3:0] s1, s2;
  logic [2:0] acc, acc_d, press;
  logic [31:0] cnt [3];
  logic [31:0] tmr, tmr_nxt, idle, idle_nxt;
  logic fault_nxt, active, pen_s;
  // Bit order of the synchronizers: {pen, mode, stop, rst}.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      acc <= '0;
      acc_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= {pen_raw, key_mode, key_stop, key_rst};
      s2 <= s1;
      acc_d <= acc;
      for (int i = 0; i < 3; i++)
        if (s2[i] == acc[i]) cnt[i] <= '0;
        else if (cnt[i] == DEBOUNCE_CYCLES - 32'd1) begin
          cnt[i] <= '0;
          acc[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 32'd1;
    end
  assign press = acc & ~acc_d;
  assign pen_s = s2[3];
  assign active = cur >= LIGHT && cur <= WRITE;
  always_comb begin
    nxt = cur;
    last_nxt = last;
    tmr_nxt = '0;
    fault_nxt = rst_fault;
    idle_nxt = (active && press == 3'b0 && !pen_s && idle != SLEEP_CYCLES - 32'd1) ? idle + 32'd1 : '0;
    if (press[0]) begin
      nxt = RST;
      fault_nxt = 1'b0;
    end else if (cur == RST) begin
      if (rst_ok || tmr == RST_TIMEOUT - 32'd1) begin
        nxt = LIGHT;
        last_nxt = LIGHT;
        fault_nxt = rst_fault | !rst_ok;
      end else tmr_nxt = tmr + 32'd1;
    end else if (press[1]) nxt = (cur == STOP) ? last : STOP;
    else if (press[2]) begin
      if (active) begin
        nxt = (cur == WRITE) ? LIGHT : mode_t'(cur + 3'd1);
        last_nxt = nxt;
      end else if (cur == SLEEP) nxt = last;
    end else if (cur == SLEEP && pen_s) nxt = last;
    else if (active && !pen_s && idle == SLEEP_CYCLES - 32'd1) nxt = SLEEP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= RST;
      last <= LIGHT;
      tmr <= '0;
      idle <= '0;
      rst_fault <= 1'b0;
      pen_we <= 1'b0;
    end else begin
      cur <= nxt;
      last <= last_nxt;
      tmr <= tmr_nxt;
      idle <= idle_nxt;
      rst_fault <= fault_nxt;
      pen_we <= pen_s && active;
    end
  assign state = cur;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed plus randomized stimulus; a cycle-level reference model
// pushes expected outputs into a scoreboard that a negedge monitor drains.
module tb_led_mode_ctrl;
  localparam int D = 4, SC = 100, RT = 50;
  localparam int RST_M = 0, LIGHT = 1, DRAW = 2, ERASE = 3, COLOR = 4, WRITE = 5, STOP = 6, SLEEP = 7;
  logic clk = 0, rst_n = 0, key_rst = 0, key_stop = 0, key_mode = 0, pen_raw = 0, rst_ok = 0;
  logic [2:0] state;
  logic pen_we, rst_fault;
  int n_chk = 0, n_fail = 0;
  logic [4:0] sb [$];

  led_mode_ctrl #(.DEBOUNCE_CYCLES(32'(D)), .SLEEP_CYCLES(32'(SC)), .RST_TIMEOUT(32'(RT))) dut (
    .clk(clk), .rst_n(rst_n), .key_rst(key_rst), .key_stop(key_stop), .key_mode(key_mode),
    .pen_raw(pen_raw), .rst_ok(rst_ok), .state(state), .pen_we(pen_we), .rst_fault(rst_fault));

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a key press is recognised once D consecutive synchronized samples
  // differ from the accepted level; the mode change lands one edge after acceptance.
  initial begin : model
    int st, last, tmr, idle;
    bit flt, pwe, pen, any, act, diff;
    bit lvl [3];
    bit pend [3];
    bit prs [3];
    logic [15:0] sh [4];
    logic [3:0] raw;
    forever begin
      @(posedge clk);
      raw = {pen_raw, key_mode, key_stop, key_rst};
      if (!rst_n) begin
        st = RST_M; last = LIGHT; tmr = 0; idle = 0; flt = 0; pwe = 0;
        for (int k = 0; k < 4; k++) sh[k] = '0;
        for (int k = 0; k < 3; k++) begin lvl[k] = 0; pend[k] = 0; end
      end else begin
        for (int k = 0; k < 3; k++) begin
          prs[k] = pend[k];
          diff = 1;
          for (int j = 1; j <= D; j++) if (sh[k][j] == lvl[k]) diff = 0;
          pend[k] = 0;
          if (diff) begin lvl[k] = !lvl[k]; pend[k] = lvl[k]; end
        end
        pen = sh[3][1];
        act = st >= LIGHT && st <= WRITE;
        any = prs[0] | prs[1] | prs[2];
        pwe = pen && act;
        if (prs[0]) begin st = RST_M; tmr = 0; flt = 0; end
        else if (st == RST_M) begin
          tmr++;
          if (rst_ok) begin st = LIGHT; last = LIGHT; tmr = 0; end
          else if (tmr == RT) begin st = LIGHT; last = LIGHT; flt = 1; tmr = 0; end
        end else if (prs[1]) st = (st == STOP) ? last : STOP;
        else if (prs[2]) begin
          if (act) begin st = (st == WRITE) ? LIGHT : st + 1; last = st; end
          else if (st == SLEEP) st = last;
        end else if (st == SLEEP && pen) st = last;
        if (!act || any || pen) idle = 0;
        else begin
          idle++;
          if (idle == SC) begin st = SLEEP; idle = 0; end
        end
        for (int k = 0; k < 4; k++) sh[k] = {sh[k][14:0], raw[k]};
      end
      sb.push_back({3'(st), pwe, flt});
    end
  end

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard empty at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (!rst_n) e = 5'b0;
        chk("sb_state", int'(state), int'(e[4:2]));
        chk("sb_pen_we", int'(pen_we), int'(e[1]));
        chk("sb_rst_fault", int'(rst_fault), int'(e[0]));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic keys(logic [2:0] m);
    {key_mode, key_stop, key_rst} = m;
  endtask

  task automatic press(logic [2:0] m, int exp);
    keys(m); tick(7); keys(3'b0); tick(7);
    chk("press_state", int'(state), exp);
  endtask

  initial begin : stim
    int seq [6] = '{LIGHT, DRAW, ERASE, COLOR, WRITE, LIGHT};
    logic [3:0] v;
    tick(3); rst_n = 1;
    chk("reset_state", int'(state), RST_M);
    tick(20);
    rst_ok = 1;
    chk("rst_hold", int'(state), RST_M);
    tick(1); rst_ok = 0;
    chk("rst_ok_exit", int'(state), LIGHT);
    chk("rst_ok_nofault", int'(rst_fault), 0);
    tick(5); rst_n = 0; tick(2); rst_n = 1;
    tick(49);
    chk("timeout_before", int'(state), RST_M);
    tick(1);
    chk("timeout_exit", int'(state), LIGHT);
    chk("timeout_fault", int'(rst_fault), 1);
    for (int i = 0; i < 5; i++) begin
      key_mode = 1; tick(6);
      chk("mode_early", int'(state), seq[i]);
      tick(1);
      chk("mode_step", int'(state), seq[i + 1]);
      key_mode = 0; tick(8);
    end
    chk("fault_sticky", int'(rst_fault), 1);
    key_mode = 1; tick(3); key_mode = 0; tick(10);
    chk("glitch", int'(state), LIGHT);
    press(3'b100, DRAW);
    press(3'b100, ERASE);
    press(3'b010, STOP);
    press(3'b100, STOP);
    pen_raw = 1; tick(5);
    chk("stop_pen_we", int'(pen_we), 0);
    pen_raw = 0; tick(3);
    press(3'b010, ERASE);
    press(3'b100, COLOR);
    press(3'b100, WRITE);
    press(3'b100, LIGHT);
    press(3'b100, DRAW);
    tick(SC - 8);
    chk("sleep_before", int'(state), DRAW);
    tick(1);
    chk("sleep_enter", int'(state), SLEEP);
    pen_raw = 1; tick(2);
    chk("wake_early", int'(state), SLEEP);
    tick(1);
    chk("wake_state", int'(state), DRAW);
    chk("wake_no_write", int'(pen_we), 0);
    tick(1);
    chk("wake_pen_we", int'(pen_we), 1);
    pen_raw = 0; tick(4);
    press(3'b100, ERASE);
    press(3'b100, COLOR);
    press(3'b111, RST_M);
    tick(3); rst_ok = 1; tick(1); rst_ok = 0;
    chk("multi_exit", int'(state), LIGHT);
    chk("multi_fault", int'(rst_fault), 0);
    press(3'b010, STOP);
    press(3'b010, LIGHT);
    press(3'b100, DRAW);
    key_mode = 1; tick(3); rst_n = 0; #1;
    chk("async_state", int'(state), RST_M);
    chk("async_pen_we", int'(pen_we), 0);
    tick(2); rst_n = 1; tick(2); key_mode = 0; tick(10);
    rst_ok = 1; tick(1); rst_ok = 0;
    for (int i = 0; i < 80; i++) begin
      v[3] = $urandom_range(0, 1) == 0;
      v[2] = $urandom_range(0, 9) < 4;
      v[1] = $urandom_range(0, 9) < 2;
      v[0] = $urandom_range(0, 19) == 0;
      {pen_raw, key_mode, key_stop, key_rst} = v;
      rst_ok = $urandom_range(0, 5) == 0;
      tick(i % 10 == 0 ? $urandom_range(90, 110) : $urandom_range(1, 12));
    end
    {pen_raw, key_mode, key_stop, key_rst} = 4'b0; rst_ok = 0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
